gray_mean_binarize: RTL and testbench
=====================================

// Module: gray_mean_binarize
// PURPOSE
//  Sits directly downstream of rgb2gray and consumes its Y_DAT/GRAY_VSYNC/GRAY_DVALID stream.
//  Binarises each gray pixel against an adaptive threshold.
//  The threshold for frame N is the floor mean of all valid pixels of frame N-1.
//  The mean is computed by a sequential divider that runs during vertical blanking.
// PARAMETERS
//  DW          8    gray pixel width
//  IW          640  nominal image width (documentation, bench sizing)
//  IH          512  nominal image height
//  CNT_W       20   pixel counter width (>= clog2(IW*IH+1))
//  INIT_THRESH 128  threshold used after reset until the first mean is available
// PORTS
//  CLOCK       in   1     system clock (same clock as upstream GRAY_CLK)
//  RSTn        in   1     async active-low reset
//  IN_VSYNC    in   1     frame active, high for the whole frame (from GRAY_VSYNC)
//  IN_DVALID   in   1     pixel valid (from GRAY_DVALID)
//  IN_Y        in   DW    gray pixel (from Y_DAT)
//  BIN_VSYNC   out  1     IN_VSYNC delayed 1 cycle
//  BIN_DVALID  out  1     IN_DVALID delayed 1 cycle
//  BIN_DAT     out  DW    all-ones if pixel >= threshold, else 0; 0 when BIN_DVALID low
//  THRESH      out  DW    threshold currently applied
//  THRESH_UPD  out  1     1-cycle pulse when THRESH loads a new value
//  DIV_ABORT   out  1     1-cycle pulse when the mean was discarded (blanking too short)
// BEHAVIOUR
//  Reset (async, RSTn=0):
//   - all outputs 0, except THRESH=INIT_THRESH
//   - sum, cnt, quotient, pending flag cleared; FSM=IDLE
//  Pixel path, latency 1:
//   - BIN_DAT = (IN_Y >= THRESH) ? {DW{1}} : 0, registered with BIN_VSYNC/BIN_DVALID
//   - a DVALID pixel while IN_VSYNC=0 is binarised but not accumulated
//  Edges: vs_r is IN_VSYNC registered; rise = IN_VSYNC & ~vs_r; fall = ~IN_VSYNC & vs_r.
//  FSM:
//   - IDLE -> ACCUM on rise:
//       clear sum/cnt, then include the pixel on the rise cycle if valid
//       if pending=1: THRESH<=next_thr, THRESH_UPD=1, pending<=0
//   - ACCUM:
//       each IN_VSYNC&IN_DVALID: sum+=IN_Y (SUM_W=CNT_W+DW bits), cnt+=1
//       when cnt is all-ones, both sum and cnt freeze (saturate)
//       on fall: cnt==0 -> IDLE, no update; else -> DIV (start divider)
//   - DIV: SUM_W+1 cycles (load + one restoring step per bit), quotient = floor(sum/cnt)
//       done: next_thr <= min(quotient, 2^DW-1), pending<=1 -> IDLE
//       rise before done: abort divider, DIV_ABORT=1, pending unchanged,
//         THRESH unchanged, enter ACCUM (treat as rise)
//  THRESH changes only on a frame-start cycle, never mid-frame.
//   Update becomes visible on BIN_DAT from the first pixel of the new frame.
//  Simultaneous rise and divider done on the same cycle: the result is accepted;
//   THRESH loads on that cycle, THRESH_UPD=1, no abort.
//  Required blanking is >= SUM_W+2 cycles (30 for defaults); shorter blanking aborts.
//  Arithmetic: unsigned only; floor division, no rounding.
// STRUCTURE
//  Shared package img_pkg:
//   - DW and CNT_W defaults, FSM state encoding (IDLE/ACCUM/DIV)
//   - function clog2
//  Sub-module seq_divider: unsigned restoring divider.
//   - ports start/abort/dividend[SUM_W]/divisor[CNT_W]/busy/done/quotient[SUM_W]
//   - reset: CLOCK, RSTn
//  Top level holds edge detect, accumulators, FSM, threshold registers and compare stage.
// TESTING (bench IW=4, IH=2, blanking 40 cycles unless stated)
//  1 Frame0 all pixels 100 -> BIN_DAT all 0 (THRESH=128); THRESH_UPD at frame1 start;
//    THRESH=100; frame1 pixels 100 -> 255.
//  2 Frame of 0..7 -> sum 28, cnt 8, THRESH=3 next frame;
//    pixels 2,3,4 -> 0,255,255.
//  3 VSYNC frame with no DVALID -> no DIV, no THRESH_UPD, THRESH unchanged.
//  4 Frame of 200s, blanking 5 cycles -> DIV_ABORT pulse 1 cycle, THRESH unchanged;
//    the following frame still accumulates correctly.
//  5 RSTn low mid-DIV -> all outputs 0 and THRESH=128 immediately;
//    after release the next frame uses 128.
//  6 Random stream -> BIN_VSYNC/BIN_DVALID equal inputs delayed exactly 1 cycle;
//    BIN_DAT matches a reference model each cycle.

Source files
------------

// File: rtl/img_pkg.sv
// rtl/img_pkg.sv - shared defaults, FSM encoding and clog2 helper for the image blocks
package img_pkg;

  localparam int DW_DEF    = 8;
  localparam int CNT_W_DEF = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DIV   = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - unsigned restoring divider, one quotient bit per cycle
module seq_divider
  import img_pkg::*;
#(
  parameter int SUM_W = 28,
  parameter int CNT_W = 20
) (
  input  logic             CLOCK,
  input  logic             RSTn,
  input  logic             start,
  input  logic             abort,
  input  logic [SUM_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [SUM_W-1:0] quotient
);

  localparam int STEP_W = clog2(SUM_W + 1);

  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [SUM_W-1:0]  quo_q, quo_d;
  logic [CNT_W-1:0]  dvs_q, dvs_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CNT_W:0]    trial;

  // Load on start, then shift the dividend MSB into the remainder and trial-subtract each cycle
  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    step_d = step_q;
    busy_d = busy_q;
    done_d = 1'b0;
    trial  = {rem_q, quo_q[SUM_W-1]};
    if (abort) begin
      busy_d = 1'b0;
    end else if (start) begin
      rem_d  = '0;
      quo_d  = dividend;
      dvs_d  = divisor;
      step_d = STEP_W'(SUM_W);
      busy_d = 1'b1;
    end else if (busy_q) begin
      // remainder stays below the divisor, so the difference always fits CNT_W bits
      if (trial >= {1'b0, dvs_q}) begin
        rem_d = CNT_W'(trial - {1'b0, dvs_q});
        quo_d = {quo_q[SUM_W-2:0], 1'b1};
      end else begin
        rem_d = trial[CNT_W-1:0];
        quo_d = {quo_q[SUM_W-2:0], 1'b0};
      end
      step_d = step_q - 1'b1;
      if (step_q == STEP_W'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // Divider state registers
  always_ff @(posedge CLOCK or negedge RSTn) begin
    if (!RSTn) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      step_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      step_q <= step_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/gray_mean_binarize.sv
// rtl/gray_mean_binarize.sv - binarise gray pixels against the previous frame's mean
module gray_mean_binarize
  import img_pkg::*;
#(
  parameter int DW          = DW_DEF,
  parameter int IW          = 640,
  parameter int IH          = 512,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int INIT_THRESH = 128
) (
  input  logic          CLOCK,
  input  logic          RSTn,
  input  logic          IN_VSYNC,
  input  logic          IN_DVALID,
  input  logic [DW-1:0] IN_Y,
  output logic          BIN_VSYNC,
  output logic          BIN_DVALID,
  output logic [DW-1:0] BIN_DAT,
  output logic [DW-1:0] THRESH,
  output logic          THRESH_UPD,
  output logic          DIV_ABORT
);

  localparam int SUM_W = CNT_W + DW;

  if (clog2(IW * IH + 1) > CNT_W) begin : g_cnt_w_check
    $error("CNT_W too small for IW*IH pixels");
  end

  state_t             state_q, state_d;
  logic               vs_q, dv_q;
  logic [DW-1:0]      bin_dat_q, bin_dat_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]      thresh_q, thresh_d;
  logic [DW-1:0]      next_thr_q, next_thr_d;
  logic               pending_q, pending_d;
  logic               thresh_upd_q, thresh_upd_d;
  logic               div_abort_q, div_abort_d;
  logic               rise, fall, frame_start;
  logic               div_start, div_abort, div_busy, div_done;
  logic [SUM_W-1:0]   div_quo;
  logic [DW-1:0]      sat_quo;

  assign rise    = IN_VSYNC & ~vs_q;
  assign fall    = ~IN_VSYNC & vs_q;
  assign sat_quo = (|div_quo[SUM_W-1:DW]) ? '1 : div_quo[DW-1:0];

  seq_divider #(.SUM_W(SUM_W), .CNT_W(CNT_W)) u_div (
    .CLOCK    (CLOCK),
    .RSTn     (RSTn),
    .start    (div_start),
    .abort    (div_abort),
    .dividend (sum_q),
    .divisor  (cnt_q),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo)
  );

  // FSM state register
  always_ff @(posedge CLOCK or negedge RSTn) begin
    if (!RSTn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state: accumulate during the frame, divide during blanking
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (rise) state_d = ST_ACCUM;
      ST_ACCUM: if (fall) state_d = (cnt_q == '0) ? ST_IDLE : ST_DIV;
      ST_DIV: begin
        if (rise)          state_d = ST_ACCUM;
        else if (div_done) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: accumulator, divider control and threshold handover at frame start
  always_comb begin
    sum_d        = sum_q;
    cnt_d        = cnt_q;
    thresh_d     = thresh_q;
    next_thr_d   = next_thr_q;
    pending_d    = pending_q;
    thresh_upd_d = 1'b0;
    div_abort_d  = 1'b0;
    div_start    = 1'b0;
    div_abort    = 1'b0;
    frame_start  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rise) begin
          frame_start = 1'b1;
          if (pending_q) begin
            thresh_d     = next_thr_q;
            thresh_upd_d = 1'b1;
            pending_d    = 1'b0;
          end
        end
      end
      ST_ACCUM: begin
        // saturated count freezes both accumulators so the mean stays consistent
        if (IN_VSYNC && IN_DVALID && cnt_q != '1) begin
          sum_d = sum_q + SUM_W'(IN_Y);
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DIV: begin
        if (rise) begin
          frame_start = 1'b1;
          // a result landing on the frame-start cycle is still usable
          if (div_done) begin
            thresh_d     = sat_quo;
            thresh_upd_d = 1'b1;
          end else begin
            div_abort   = 1'b1;
            div_abort_d = 1'b1;
          end
        end else if (div_done) begin
          next_thr_d = sat_quo;
          pending_d  = 1'b1;
        end else if (!div_busy) begin
          div_start = 1'b1;
        end
      end
      default: ;
    endcase
    if (frame_start) begin
      sum_d = IN_DVALID ? SUM_W'(IN_Y) : '0;
      cnt_d = IN_DVALID ? CNT_W'(1) : '0;
    end
  end

  // Compare against the threshold in force this cycle, including one loading right now
  always_comb begin
    bin_dat_d = (IN_DVALID && (IN_Y >= thresh_d)) ? '1 : '0;
  end

  // Datapath, threshold and pulse registers
  always_ff @(posedge CLOCK or negedge RSTn) begin
    if (!RSTn) begin
      vs_q         <= 1'b0;
      dv_q         <= 1'b0;
      bin_dat_q    <= '0;
      sum_q        <= '0;
      cnt_q        <= '0;
      thresh_q     <= DW'(INIT_THRESH);
      next_thr_q   <= '0;
      pending_q    <= 1'b0;
      thresh_upd_q <= 1'b0;
      div_abort_q  <= 1'b0;
    end else begin
      vs_q         <= IN_VSYNC;
      dv_q         <= IN_DVALID;
      bin_dat_q    <= bin_dat_d;
      sum_q        <= sum_d;
      cnt_q        <= cnt_d;
      thresh_q     <= thresh_d;
      next_thr_q   <= next_thr_d;
      pending_q    <= pending_d;
      thresh_upd_q <= thresh_upd_d;
      div_abort_q  <= div_abort_d;
    end
  end

  assign BIN_VSYNC  = vs_q;
  assign BIN_DVALID = dv_q;
  assign BIN_DAT    = bin_dat_q;
  assign THRESH     = thresh_q;
  assign THRESH_UPD = thresh_upd_q;
  assign DIV_ABORT  = div_abort_q;

endmodule

// File: tb/tb_gray_mean_binarize.sv
// tb/tb_gray_mean_binarize.sv - self-checking bench for gray_mean_binarize
module tb_gray_mean_binarize;

  localparam int DW          = 8;
  localparam int IW          = 4;
  localparam int IH          = 2;
  localparam int CNT_W       = 20;
  localparam int SUM_W       = CNT_W + DW;
  localparam int GAP_MIN     = SUM_W + 2;
  localparam int INIT_THRESH = 128;

  logic          CLOCK = 1'b0;
  logic          RSTn = 1'b0;
  logic          IN_VSYNC = 1'b0;
  logic          IN_DVALID = 1'b0;
  logic [DW-1:0] IN_Y = '0;
  logic          BIN_VSYNC, BIN_DVALID, THRESH_UPD, DIV_ABORT;
  logic [DW-1:0] BIN_DAT, THRESH;

  int total = 0;
  int bad = 0;

  always #5 CLOCK = ~CLOCK;

  gray_mean_binarize #(
    .DW(DW), .IW(IW), .IH(IH), .CNT_W(CNT_W), .INIT_THRESH(INIT_THRESH)
  ) dut (
    .CLOCK      (CLOCK),
    .RSTn       (RSTn),
    .IN_VSYNC   (IN_VSYNC),
    .IN_DVALID  (IN_DVALID),
    .IN_Y       (IN_Y),
    .BIN_VSYNC  (BIN_VSYNC),
    .BIN_DVALID (BIN_DVALID),
    .BIN_DAT    (BIN_DAT),
    .THRESH     (THRESH),
    .THRESH_UPD (THRESH_UPD),
    .DIV_ABORT  (DIV_ABORT)
  );

  // Frame-level reference: threshold of a frame is the mean of the previous frame,
  // applied only when the blanking gap before it was long enough for the division.
  bit m_vs, m_cand;
  int m_sum, m_cnt, m_mean, m_gap, m_thr;

  task automatic model_reset();
    m_vs = 0; m_cand = 0; m_sum = 0; m_cnt = 0; m_mean = 0; m_gap = 0;
    m_thr = INIT_THRESH;
  endtask

  task automatic step(input bit vs, input bit dv, input int y);
    bit e_upd, e_ab;
    int e_dat;
    e_upd = 0;
    e_ab  = 0;
    IN_VSYNC  = vs;
    IN_DVALID = dv;
    IN_Y      = y[DW-1:0];
    if (vs && !m_vs) begin
      if (m_cand) begin
        if (m_gap >= GAP_MIN) begin
          m_thr = (m_mean > 255) ? 255 : m_mean;
          e_upd = 1;
        end else begin
          e_ab = 1;
        end
      end
      m_cand = 0; m_sum = 0; m_cnt = 0;
    end
    if (vs && dv) begin
      m_sum += y[DW-1:0];
      m_cnt++;
    end
    if (!vs && m_vs) begin
      m_cand = (m_cnt > 0);
      if (m_cnt > 0) m_mean = m_sum / m_cnt;
      m_gap = 0;
    end
    if (!vs) m_gap++;
    m_vs = vs;
    e_dat = (dv && (y[DW-1:0] >= m_thr)) ? 255 : 0;
    @(posedge CLOCK);
    #1;
    total++;
    if (BIN_VSYNC !== vs || BIN_DVALID !== dv || BIN_DAT !== DW'(e_dat) ||
        THRESH !== DW'(m_thr) || THRESH_UPD !== e_upd || DIV_ABORT !== e_ab) begin
      bad++;
      $display("FAIL cycle t=%0t got vs=%0b dv=%0b dat=%0d thr=%0d upd=%0b ab=%0b want vs=%0b dv=%0b dat=%0d thr=%0d upd=%0b ab=%0b",
               $time, BIN_VSYNC, BIN_DVALID, BIN_DAT, THRESH, THRESH_UPD, DIV_ABORT,
               vs, dv, e_dat, m_thr, e_upd, e_ab);
    end
    @(negedge CLOCK);
  endtask

  typedef struct {
    int base;
    int inc;
    bit dv;
    int blank;
    int exp_thr;
    bit exp_upd;
    bit exp_ab;
  } frame_vec_t;

  frame_vec_t vecs[11];

  task automatic check_start(input frame_vec_t v, input string name);
    total++;
    if (THRESH !== DW'(v.exp_thr) || THRESH_UPD !== v.exp_upd || DIV_ABORT !== v.exp_ab) begin
      bad++;
      $display("FAIL %s frame start: got thr=%0d upd=%0b ab=%0b want thr=%0d upd=%0b ab=%0b",
               name, THRESH, THRESH_UPD, DIV_ABORT, v.exp_thr, v.exp_upd, v.exp_ab);
    end
  endtask

  task automatic play_frame(input frame_vec_t v, input string name);
    int k;
    k = 0;
    for (int r = 0; r < IH; r++) begin
      for (int c = 0; c < IW; c++) begin
        step(1'b1, v.dv, v.base + v.inc * k);
        k++;
        if (r == 0 && c == 0) check_start(v, name);
      end
      step(1'b1, 1'b0, 0);
      step(1'b1, 1'b0, 0);
    end
    for (int b = 0; b < v.blank; b++) step(1'b0, 1'b0, 0);
  endtask

  task automatic check_reset(input string name);
    total++;
    if (BIN_VSYNC !== 1'b0 || BIN_DVALID !== 1'b0 || BIN_DAT !== '0 ||
        THRESH !== DW'(INIT_THRESH) || THRESH_UPD !== 1'b0 || DIV_ABORT !== 1'b0) begin
      bad++;
      $display("FAIL %s: got vs=%0b dv=%0b dat=%0d thr=%0d upd=%0b ab=%0b want all 0 thr=%0d",
               name, BIN_VSYNC, BIN_DVALID, BIN_DAT, THRESH, THRESH_UPD, DIV_ABORT, INIT_THRESH);
    end
  endtask

  initial begin
    frame_vec_t v;
    int nb;

    //          base inc dv blank thr upd ab
    vecs[0]  = '{100, 0, 1'b1, 40, 128, 1'b0, 1'b0};
    vecs[1]  = '{100, 0, 1'b1, 40, 100, 1'b1, 1'b0};
    vecs[2]  = '{  0, 1, 1'b1, 40, 100, 1'b1, 1'b0};
    vecs[3]  = '{  0, 1, 1'b1, 40,   3, 1'b1, 1'b0};
    vecs[4]  = '{  0, 0, 1'b0, 40,   3, 1'b1, 1'b0};
    vecs[5]  = '{200, 0, 1'b1,  5,   3, 1'b0, 1'b0};
    vecs[6]  = '{ 50, 0, 1'b1, 40,   3, 1'b0, 1'b1};
    vecs[7]  = '{  0, 1, 1'b1, 30,  50, 1'b1, 1'b0};
    vecs[8]  = '{200, 0, 1'b1, 29,   3, 1'b1, 1'b0};
    vecs[9]  = '{ 10, 10, 1'b1, 40,  3, 1'b0, 1'b1};
    vecs[10] = '{  0, 0, 1'b1, 40,  45, 1'b1, 1'b0};

    model_reset();
    repeat (3) @(negedge CLOCK);
    check_reset("reset_state");
    RSTn = 1'b1;

    for (int i = 0; i < 11; i++) play_frame(vecs[i], $sformatf("vec%0d", i));

    // reset while the divider is mid-run
    v = '{200, 0, 1'b1, 10, 0, 1'b1, 1'b0};
    play_frame(v, "pre_reset");
    #2;
    RSTn = 1'b0;
    #1;
    check_reset("reset_mid_div");
    model_reset();
    IN_VSYNC = 1'b0; IN_DVALID = 1'b0; IN_Y = '0;
    repeat (2) @(negedge CLOCK);
    RSTn = 1'b1;
    v = '{100, 0, 1'b1, 40, 128, 1'b0, 1'b0};
    play_frame(v, "post_reset");
    v = '{0, 0, 1'b1, 40, 100, 1'b1, 1'b0};
    play_frame(v, "post_reset_next");

    // random frames, random valid gaps, pixels during blanking, random blanking lengths
    for (int f = 0; f < 30; f++) begin
      for (int r = 0; r < IH; r++)
        for (int c = 0; c < IW + 2; c++)
          step(1'b1, $urandom_range(0, 3) != 0, int'($urandom_range(0, 255)));
      nb = int'($urandom_range(5, 45));
      for (int b = 0; b < nb; b++)
        step(1'b0, $urandom_range(0, 1) != 0, int'($urandom_range(0, 255)));
    end
    step(1'b1, 1'b1, 128);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
